wah_svf: RTL and testbench
==========================

# wah_svf

Chamberlin state-variable band-pass filter that turns the wah chain's control path into audio. It sits directly downstream of `cutoff_freq_unit` inside `wah`. Each 96 kHz sample, it takes `sample_in` and the current `cutoff_freq`, runs one filter iteration on a single time-shared multiplier, and drives the band-pass result as the wah output. The 96 kHz rate is carried as a one-cycle strobe in the 96 MHz domain; the top level derives that strobe from `clock_divider`.

## Interface
- `SAMPLE_WIDTH`, 24: audio sample width, signed two's complement.
- `GUARD_BITS`, 4: extra integer bits on the internal state registers.
- `system_clock`  in  1: 96 MHz system clock; the only clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `sample_valid`  in  1: one-cycle strobe; a new sample and coefficients are present.
- `sample_in`  in  SAMPLE_WIDTH: signed input sample.
- `cutoff_freq`  in  SAMPLE_WIDTH: tuning coefficient f, unsigned Q8.16.
- `q_damp`  in  8: damping coefficient q, unsigned Q1.7 (0x80 = 1.0).
- `filter_out`  out  SAMPLE_WIDTH: signed band-pass output, registered.
- `out_valid`  out  1: one-cycle pulse when `filter_out` updates.
- `busy`  out  1: an iteration is in progress.
- `overrun`  out  1: one-cycle pulse when a `sample_valid` is dropped.

## Operation
- State registers `low` and `band` are signed, W = SAMPLE_WIDTH+GUARD_BITS bits.
- `high` is a signed W-bit working register.
- Capture: in IDLE, `sample_valid`=1 latches `sample_in` (sign-extended to W) and latches the coefficients.
  - f: `cutoff_freq` clamped to F_MAX = 0x010000 (1.0), so f ≤ 1.0.
  - q: `q_damp`.
- The FSM then runs IDLE → LOW → HIGH → BAND → IDLE. Each active state does exactly one multiply:
  - LOW: `low` ← sat(`low` + (f·`band` >>> 16)).
  - HIGH: `high` ← sat(x − `low` − (q·`band` >>> 7)). This uses the `low` value updated in LOW.
  - BAND: `band` ← sat(`band` + (f·`high` >>> 16)). In the same edge, `filter_out` ← satS(new `band`) and `out_valid` ← 1.
- Arithmetic rules:
  - Multiplier is signed W × 18 (coefficients zero-extended).
  - `>>>` is an arithmetic shift (truncation toward −∞).
  - sat() clips to the W-bit signed range.
  - satS() clips to the SAMPLE_WIDTH range: 0x7FFFFF / 0x800000 at default width.
  - Nothing ever wraps.
- `sample_valid` outside IDLE is ignored, and `overrun` pulses for one cycle. The dropped sample does not alter state, coefficients or output.
- Coefficient changes between strobes have no effect until the next capture.
- Reset values:
  - FSM = IDLE.
  - `low`, `band`, `high`, `filter_out` = 0.
  - `out_valid`, `busy`, `overrun` = 0.
- Reset mid-iteration aborts it. No `out_valid` is produced; the filter restarts from zero state.

## Timing
- Edge 0: `sample_valid` sampled high in IDLE; FSM → LOW; `busy` = 1 after edge 0.
- Edge 1: `low` updated; FSM → HIGH.
- Edge 2: `high` updated; FSM → BAND.
- Edge 3: `band` and `filter_out` updated; `out_valid` = 1 for cycle 3→4; `busy` = 0; FSM → IDLE.
- Latency is 3 cycles from strobe to `out_valid`. Minimum accepted strobe spacing is 4 cycles; the nominal spacing is 1000.
- A strobe coincident with edge 3 (FSM in BAND) is dropped with `overrun`. A strobe at edge 4 is accepted.
- `filter_out` holds its value between `out_valid` pulses.

## Structure
- `wah_pkg` holds:
  - the FSM enum `svf_state_t` {IDLE, LOW, HIGH, BAND};
  - the constants `F_FRAC`=16, `Q_FRAC`=7, `F_MAX`=24'h010000, `GUARD_BITS`=4.
- Sub-module `wah_mul_sat`: combinational signed W×18 multiply, parameterised arithmetic right shift, saturation to W bits.
  - Instantiated once; its operands are muxed by the FSM state.
- Saturating adds and the satS() output clip live in `wah_svf`.

## Test plan
- Reset: hold `rst_n`=0 with random inputs toggling → `filter_out`=0, `out_valid`=0, `busy`=0, `overrun`=0; first strobe after release starts from zero state.
- Impulse: f=0x008000, q=0x80; strobe with `sample_in`=0x100000 → 3 cycles later `filter_out`=0x080000; next strobe with 0x000000 → `filter_out`=0x020000.
- Zero cutoff: `cutoff_freq`=0, 100 strobes of random `sample_in` → every `filter_out`=0.
- Clamp/saturation:
  - `cutoff_freq`=0x0FFFFF gives results bit-identical to 0x010000.
  - With f=1.0, q=0 and `sample_in`=0x7FFFFF for 200 strobes, `filter_out` stays within [0x800000, 0x7FFFFF] and never changes sign except through a value of 0x7FFFFF or 0x800000.
- Overrun: strobe, then a second strobe at edge 2 and another at edge 3 → two `overrun` pulses, one `out_valid`, output equal to the single-strobe reference; a strobe at edge 4 is accepted.
- Reset mid-iteration: assert `rst_n`=0 at edge 2 of an iteration → no `out_valid`; after release, the impulse scenario reproduces 0x080000.

Source files
------------

// File: rtl/wah_pkg.sv
// Shared types and fixed-point constants for the wah state-variable filter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wah_pkg;

    // One filter iteration walks IDLE -> LOW -> HIGH -> BAND -> IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        BAND = 2'd3
    } svf_state_t;

    localparam int          F_FRAC     = 16;           // cutoff coefficient is Q8.16
    localparam int          Q_FRAC     = 7;            // damping coefficient is Q1.7
    localparam logic [23:0] F_MAX      = 24'h010000;   // f clamped to 1.0 for stability
    localparam int          GUARD_BITS = 4;            // extra integer bits on filter state

endpackage

// File: rtl/wah_mul_sat.sv
// Combinational signed W x 18 multiply, arithmetic right shift, clip to W bits.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; operands are muxed by the caller every cycle.
//
// Ports: a (signed W-bit state), b (18-bit coefficient, caller zero-extends so it
// is always non-negative), shift (right-shift amount), y (saturated W-bit result).
module wah_mul_sat #(
    parameter int W = 28
) (
    input  logic signed [W-1:0] a,
    input  logic        [17:0]  b,
    input  logic        [4:0]   shift,
    output logic signed [W-1:0] y
);

    logic signed [W+17:0] prod;
    logic signed [W+17:0] shr;
    logic        [18:0]   top_bits;

    always_comb begin
        prod     = a * $signed(b);
        // >>> floors toward -inf, matching the filter's truncation rule
        shr      = prod >>> shift;
        // The result fits in W bits only if everything above bit W-2 is a sign copy
        top_bits = shr[W+17:W-1];
        if ((top_bits == '0) || (top_bits == '1)) begin
            y = shr[W-1:0];
        end else if (shr[W+17]) begin
            y = {1'b1, {(W-1){1'b0}}};
        end else begin
            y = {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/wah_svf.sv
// Chamberlin state-variable band-pass filter, one iteration per sample strobe.
// Latency: 3 cycles from accepted sample_valid to out_valid.
// Backpressure: none; a strobe arriving mid-iteration is dropped and overrun pulses.
//
// Ports: system_clock/rst_n (async active-low), sample_valid + sample_in + cutoff_freq
// (Q8.16) + q_damp (Q1.7) captured in IDLE; filter_out/out_valid carry the band-pass
// result; busy is high while an iteration runs; overrun flags a dropped strobe.
module wah_svf #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int GUARD_BITS   = wah_pkg::GUARD_BITS
) (
    input  logic                    system_clock,
    input  logic                    rst_n,
    input  logic                    sample_valid,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic [SAMPLE_WIDTH-1:0] cutoff_freq,
    input  logic [7:0]              q_damp,
    output logic [SAMPLE_WIDTH-1:0] filter_out,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    overrun
);

    import wah_pkg::*;

    localparam int W  = SAMPLE_WIDTH + GUARD_BITS;
    localparam int FW = F_FRAC + 1;     // clamped f never exceeds 1.0, so 17 bits suffice

    svf_state_t               state_q, state_d;
    logic signed [W-1:0]      x_q, x_d;
    logic        [FW-1:0]     f_q, f_d;
    logic        [7:0]        q_q, q_d;
    logic signed [W-1:0]      low_q, low_d;
    logic signed [W-1:0]      band_q, band_d;
    logic signed [W-1:0]      high_q, high_d;
    logic [SAMPLE_WIDTH-1:0]  filter_out_q, filter_out_d;
    logic                     out_valid_q, out_valid_d;
    logic                     busy_q, busy_d;
    logic                     overrun_q, overrun_d;

    logic signed [W-1:0]      mul_a;
    logic        [17:0]       mul_b;
    logic        [4:0]        mul_sh;
    logic signed [W-1:0]      mul_y;

    // Two guard bits are enough for a sum/difference of three W-bit terms
    function automatic logic signed [W+1:0] ext2(input logic signed [W-1:0] v);
        return {{2{v[W-1]}}, v};
    endfunction

    function automatic logic signed [W-1:0] sat_w(input logic signed [W+1:0] v);
        logic [2:0] t;
        t = v[W+1:W-1];
        if ((t == 3'b000) || (t == 3'b111)) begin
            return v[W-1:0];
        end else if (v[W+1]) begin
            return {1'b1, {(W-1){1'b0}}};
        end else begin
            return {1'b0, {(W-1){1'b1}}};
        end
    endfunction

    function automatic logic [SAMPLE_WIDTH-1:0] sat_s(input logic signed [W-1:0] v);
        logic [GUARD_BITS:0] t;
        t = v[W-1:SAMPLE_WIDTH-1];
        if ((t == '0) || (t == '1)) begin
            return v[SAMPLE_WIDTH-1:0];
        end else if (v[W-1]) begin
            return {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
        end else begin
            return {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
        end
    endfunction

    // Single shared multiplier: operands selected by the active state
    always_comb begin
        mul_a  = band_q;
        mul_b  = {1'b0, f_q};
        mul_sh = 5'(F_FRAC);
        case (state_q)
            HIGH: begin
                mul_b  = {10'b0, q_q};
                mul_sh = 5'(Q_FRAC);
            end
            BAND:    mul_a = high_q;
            default: ;
        endcase
    end

    wah_mul_sat #(.W(W)) u_mul (
        .a     (mul_a),
        .b     (mul_b),
        .shift (mul_sh),
        .y     (mul_y)
    );

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        f_d          = f_q;
        q_d          = q_q;
        low_d        = low_q;
        band_d       = band_q;
        high_d       = high_q;
        filter_out_d = filter_out_q;
        out_valid_d  = 1'b0;
        overrun_d    = sample_valid && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    x_d = {{GUARD_BITS{sample_in[SAMPLE_WIDTH-1]}}, sample_in};
                    if (cutoff_freq > SAMPLE_WIDTH'(F_MAX)) begin
                        f_d = FW'(F_MAX);
                    end else begin
                        f_d = cutoff_freq[FW-1:0];
                    end
                    q_d     = q_damp;
                    state_d = LOW;
                end
            end
            LOW: begin
                low_d   = sat_w(ext2(low_q) + ext2(mul_y));
                state_d = HIGH;
            end
            HIGH: begin
                // low_q already holds this iteration's updated low
                high_d  = sat_w(ext2(x_q) - ext2(low_q) - ext2(mul_y));
                state_d = BAND;
            end
            BAND: begin
                band_d       = sat_w(ext2(band_q) + ext2(mul_y));
                filter_out_d = sat_s(band_d);
                out_valid_d  = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge system_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            x_q          <= '0;
            f_q          <= '0;
            q_q          <= '0;
            low_q        <= '0;
            band_q       <= '0;
            high_q       <= '0;
            filter_out_q <= '0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            f_q          <= f_d;
            q_q          <= q_d;
            low_q        <= low_d;
            band_q       <= band_d;
            high_q       <= high_d;
            filter_out_q <= filter_out_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign filter_out = filter_out_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_wah_svf.sv
// Scoreboard bench for wah_svf: driver pushes hand-computed expected outputs,
// a negedge monitor pops and compares on every out_valid.
// Timing: inputs driven 1 ns after posedge, outputs sampled on negedge.
module tb_wah_svf;

    logic        system_clock = 1'b0;
    logic        rst_n;
    logic        sample_valid;
    logic [23:0] sample_in;
    logic [23:0] cutoff_freq;
    logic [7:0]  q_damp;
    logic [23:0] filter_out;
    logic        out_valid;
    logic        busy;
    logic        overrun;

    always #5 system_clock = ~system_clock;

    wah_svf #(.SAMPLE_WIDTH(24), .GUARD_BITS(4)) dut (
        .system_clock (system_clock),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .cutoff_freq  (cutoff_freq),
        .q_damp       (q_damp),
        .filter_out   (filter_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    typedef struct {
        logic [23:0] dat;
        int          due;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   ovr_cnt  = 0;
    int   out_cnt  = 0;

    localparam logic [23:0] XP = 24'h7FFFFF;
    localparam logic [23:0] XN = 24'h800001;   // -0x7FFFFF
    logic [23:0] pat [6] = '{XP, XP, 24'h0, XN, XN, 24'h0};

    always @(posedge system_clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Monitor: every out_valid must match the oldest expectation, on time
    always @(negedge system_clock) begin
        if (overrun === 1'b1) ovr_cnt++;
        if (out_valid === 1'b1) begin
            out_cnt++;
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got 0x%0h expected no output", filter_out);
            end else begin
                mon_e = sbq.pop_front();
                chk("filter_out", {8'h0, filter_out}, {8'h0, mon_e.dat});
                chk("latency", cyc, mon_e.due);
            end
        end
    end

    // One accepted sample: strobe sampled at edge0, busy checked after edge0 and edge3
    task automatic strobe(input logic [23:0] x, input logic [23:0] f,
                          input logic [7:0] q, input logic [23:0] exp_v);
        @(posedge system_clock); #1;
        sample_valid = 1'b1;
        sample_in    = x;
        cutoff_freq  = f;
        q_damp       = q;
        sbq.push_back('{exp_v, cyc + 4});
        @(posedge system_clock); #1;
        sample_valid = 1'b0;
        // scramble so any failure to latch shows up
        sample_in    = 24'($urandom);
        cutoff_freq  = 24'($urandom);
        q_damp       = 8'($urandom);
        chk("busy_after_edge0", {31'h0, busy}, 32'h1);
        repeat (3) @(posedge system_clock);
        #1;
        chk("busy_after_edge3", {31'h0, busy}, 32'h0);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 50) begin
            @(posedge system_clock);
            t++;
        end
        @(negedge system_clock);
        chk(name, sbq.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge system_clock); #1;
        sample_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge system_clock);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish before 1 ms");
        $fatal(1);
    end

    initial begin
        int base;
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        cutoff_freq  = '0;
        q_damp       = '0;

        // Reset held with inputs toggling
        for (int i = 0; i < 6; i++) begin
            @(posedge system_clock); #1;
            sample_valid = 1'($urandom);
            sample_in    = 24'($urandom);
            cutoff_freq  = 24'($urandom);
            q_damp       = 8'($urandom);
            #2;
            chk("rst_filter_out", {8'h0, filter_out}, 32'h0);
            chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
            chk("rst_busy", {31'h0, busy}, 32'h0);
            chk("rst_overrun", {31'h0, overrun}, 32'h0);
        end
        sample_valid = 1'b0;
        @(posedge system_clock); #1;
        rst_n = 1'b1;

        // Impulse response, f = 0.5, q = 1.0
        strobe(24'h100000, 24'h008000, 8'h80, 24'h080000);
        strobe(24'h000000, 24'h008000, 8'h80, 24'h020000);
        strobe(24'h000000, 24'h008000, 8'h80, 24'hFE8000);
        drain("impulse_drain");

        // Zero cutoff: state never moves off zero
        do_reset();
        for (int i = 0; i < 100; i++) begin
            strobe(24'($urandom), 24'h000000, 8'($urandom), 24'h000000);
        end
        drain("zero_cutoff_drain");

        // Clamp: 0x0FFFFF must behave exactly like 1.0
        do_reset();
        strobe(24'h100000, 24'h010000, 8'h80, 24'h100000);
        strobe(24'h000000, 24'h010000, 8'h80, 24'hF00000);
        strobe(24'h000000, 24'h010000, 8'h80, 24'h000000);
        drain("clamp_ref_drain");
        do_reset();
        strobe(24'h100000, 24'h0FFFFF, 8'h80, 24'h100000);
        strobe(24'h000000, 24'h0FFFFF, 8'h80, 24'hF00000);
        strobe(24'h000000, 24'h0FFFFF, 8'h80, 24'h000000);
        drain("clamp_drain");

        // Output clip: band reaches -3*0x7FFFFF, must pin at 0x800000
        do_reset();
        strobe(XP, 24'h010000, 8'h00, XP);
        strobe(XP, 24'h010000, 8'h00, XP);
        strobe(XP, 24'h010000, 8'h00, 24'h000000);
        strobe(XN, 24'h010000, 8'h00, 24'h800000);
        drain("sat_drain");

        // f = 1.0, q = 0, constant full-scale input: period-6 limit cycle
        do_reset();
        for (int i = 0; i < 200; i++) begin
            strobe(XP, 24'h010000, 8'h00, pat[i % 6]);
        end
        drain("undamped_drain");

        // Overrun: strobes at edge2 and edge3 dropped, edge4 accepted
        do_reset();
        ovr_cnt = 0;
        base    = out_cnt;
        @(posedge system_clock); #1;
        sample_valid = 1'b1; sample_in = 24'h100000; cutoff_freq = 24'h008000; q_damp = 8'h80;
        sbq.push_back('{24'h080000, cyc + 4});
        @(posedge system_clock); #1;           // after edge0
        sample_valid = 1'b0;
        @(posedge system_clock); #1;           // after edge1
        sample_valid = 1'b1; sample_in = 24'h7FFFFF; cutoff_freq = 24'h010000; q_damp = 8'h00;
        @(posedge system_clock); #1;           // after edge2
        sample_in = 24'h123456;
        @(posedge system_clock); #1;           // after edge3
        sample_in = 24'h000000; cutoff_freq = 24'h008000; q_damp = 8'h80;
        sbq.push_back('{24'h020000, cyc + 4});
        @(posedge system_clock); #1;           // after edge4
        sample_valid = 1'b0;
        repeat (4) @(posedge system_clock);
        drain("overrun_drain");
        chk("overrun_count", ovr_cnt, 2);
        chk("overrun_out_count", out_cnt - base, 2);

        // Reset after edge2 of an iteration: no output, then clean restart
        do_reset();
        base = out_cnt;
        @(posedge system_clock); #1;
        sample_valid = 1'b1; sample_in = 24'h100000; cutoff_freq = 24'h008000; q_damp = 8'h80;
        @(posedge system_clock); #1;           // after edge0
        sample_valid = 1'b0;
        @(posedge system_clock); #1;           // after edge1
        @(posedge system_clock); #1;           // after edge2
        rst_n = 1'b0;
        repeat (6) @(posedge system_clock);
        #1;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_filter_out", {8'h0, filter_out}, 32'h0);
        chk("abort_out_count", out_cnt - base, 0);
        rst_n = 1'b1;
        strobe(24'h100000, 24'h008000, 8'h80, 24'h080000);
        strobe(24'h000000, 24'h008000, 8'h80, 24'h020000);
        drain("restart_drain");
        repeat (10) @(posedge system_clock);
        #1;
        chk("filter_out_hold", {8'h0, filter_out}, 32'h020000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
